adc_spi_reg_reader: RTL and testbench

SPI master that reads back ADC configuration registers over the ADC control SPI bus (SS0/SCLK/MOSI/MISO). It is the read-direction counterpart to the existing write-only configuration master. It issues an RREG command frame, then a NOP frame during which the register contents are shifted in on MISO, and returns the byte with an echo-check flag. It sits beside the configuration writer in the top level; bus ownership between the two is switched by an external mux driven from `busy`.

---
 rtl/adc_spi_pkg.sv | 22 ++
 rtl/spi_mode1_shifter.sv | 66 ++++++
 rtl/adc_spi_reg_reader.sv | 129 ++++++++++++
 tb/tb_adc_spi_reg_reader.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_spi_pkg.sv
// Shared definitions for the ADC control SPI masters.
// Frame constants, FSM states and the RREG command builder.
package adc_spi_pkg;

   localparam logic [2:0]  RREG_OP    = 3'b001;
   localparam logic [15:0] NOP_CMD    = 16'h0000;
   localparam int          FRAME_BITS = 16;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT,
      HOLD,
      GAP,
      DONE
   } state_t;

   function automatic logic [15:0] rreg_cmd(input logic [4:0] addr);
      return {RREG_OP, addr, 8'h00};
   endfunction

endpackage

// File: rtl/spi_mode1_shifter.sv
// 16-bit SPI mode 1 shift engine (CPOL=0, CPHA=1, MSB first).
// sdo changes with sck rising, sdi is captured with sck falling.
module spi_mode1_shifter
   import adc_spi_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] tx,
   output logic        done,
   output logic [15:0] rx,
   output logic        sck,
   output logic        sdo,
   input  logic        sdi
);

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
   localparam logic [3:0] BIT_LAST = 4'(FRAME_BITS - 1);

   logic        active;
   logic [7:0]  div;
   logic [3:0]  bit_cnt;
   logic [15:0] tx_sr;

   // High for the final low half-period of bit 0
   assign done = active && !sck && (div == 8'd0) && (bit_cnt == 4'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active  <= 1'b0;
         div     <= 8'd0;
         bit_cnt <= 4'd0;
         tx_sr   <= 16'h0000;
         rx      <= 16'h0000;
         sck     <= 1'b0;
         sdo     <= 1'b0;
      end else if (start && !active) begin
         active  <= 1'b1;
         sck     <= 1'b1;
         sdo     <= tx[15];
         tx_sr   <= {tx[14:0], 1'b0};
         div     <= DIV_LAST;
         bit_cnt <= BIT_LAST;
      end else if (active) begin
         if (div != 8'd0) begin
            div <= div - 8'd1;
         end else if (sck) begin
            sck <= 1'b0;
            rx  <= {rx[14:0], sdi};
            div <= DIV_LAST;
         end else if (bit_cnt == 4'd0) begin
            active <= 1'b0;
            sdo    <= 1'b0;
         end else begin
            sck     <= 1'b1;
            sdo     <= tx_sr[15];
            tx_sr   <= {tx_sr[14:0], 1'b0};
            bit_cnt <= bit_cnt - 4'd1;
            div     <= DIV_LAST;
         end
      end
   end

endmodule

// File: rtl/adc_spi_reg_reader.sv
// ADC register read master: RREG frame, gap, NOP frame with MISO capture.
// Returns the low byte and flags a mismatch of the echoed command byte.
module adc_spi_reg_reader
   import adc_spi_pkg::*;
#(
   parameter int CLK_DIV  = 4,
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 2,
   parameter int CS_GAP   = 8
) (
   input  logic       FPGA_CLK1_32,
   input  logic       reset_n,
   input  logic       req_valid,
   input  logic [4:0] req_addr,
   output logic       req_ready,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   output logic       rsp_err,
   output logic       busy,
   output logic       ss,
   output logic       sck,
   output logic       sdo,
   input  logic       sdi
);

   localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
   localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);
   localparam logic [7:0] GAP_LAST   = 8'(CS_GAP - 1);

   state_t      state;
   logic [4:0]  addr;
   logic        frame;
   logic [7:0]  wait_cnt;
   logic        start;
   logic        done;
   logic [15:0] tx;
   logic [15:0] rx;

   assign tx    = frame ? NOP_CMD : rreg_cmd(addr);
   assign start = (state == SETUP) && (wait_cnt == 8'd0);

   spi_mode1_shifter #(
      .CLK_DIV(CLK_DIV)
   ) u_shifter (
      .clk  (FPGA_CLK1_32),
      .rst_n(reset_n),
      .start(start),
      .tx   (tx),
      .done (done),
      .rx   (rx),
      .sck  (sck),
      .sdo  (sdo),
      .sdi  (sdi)
   );

   always_ff @(posedge FPGA_CLK1_32 or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         addr      <= 5'd0;
         frame     <= 1'b0;
         wait_cnt  <= 8'd0;
         req_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_data  <= 8'h00;
         rsp_err   <= 1'b0;
         busy      <= 1'b0;
         ss        <= 1'b1;
      end else begin
         rsp_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  addr      <= req_addr;
                  frame     <= 1'b0;
                  wait_cnt  <= SETUP_LAST;
                  req_ready <= 1'b0;
                  busy      <= 1'b1;
                  ss        <= 1'b0;
                  state     <= SETUP;
               end else begin
                  req_ready <= 1'b1;
               end
            end
            SETUP: begin
               if (wait_cnt == 8'd0) state <= SHIFT;
               else wait_cnt <= wait_cnt - 8'd1;
            end
            SHIFT: begin
               if (done) begin
                  wait_cnt <= HOLD_LAST;
                  state    <= HOLD;
               end
            end
            HOLD: begin
               if (wait_cnt != 8'd0) begin
                  wait_cnt <= wait_cnt - 8'd1;
               end else if (!frame) begin
                  ss       <= 1'b1;
                  wait_cnt <= GAP_LAST;
                  state    <= GAP;
               end else begin
                  ss        <= 1'b1;
                  rsp_valid <= 1'b1;
                  rsp_data  <= rx[7:0];
                  rsp_err   <= rx[15:8] != {RREG_OP, addr};
                  state     <= DONE;
               end
            end
            GAP: begin
               if (wait_cnt != 8'd0) begin
                  wait_cnt <= wait_cnt - 8'd1;
               end else begin
                  frame    <= 1'b1;
                  ss       <= 1'b0;
                  wait_cnt <= SETUP_LAST;
                  state    <= SETUP;
               end
            end
            DONE: begin
               busy      <= 1'b0;
               req_ready <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_adc_spi_reg_reader.sv
// Bench for adc_spi_reg_reader at CLK_DIV 2, 1 and 255 with a mode-1
// slave model, bus monitor and frame-level reference expectations.
`timescale 1ns/1ps
module tb_adc_spi_reg_reader;

   localparam int CS_SETUP = 2;
   localparam int CS_HOLD  = 2;
   localparam int CS_GAP   = 8;
   localparam int LIMIT    = 20000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [2:0] req_valid = '0;
   logic [2:0][4:0] req_addr = '0;
   logic sdi;

   wire [2:0] req_ready, rsp_valid, rsp_err, busy, ss, sck, sdo;
   wire [2:0][7:0] rsp_data;

   int n_cmp = 0;
   int n_bad = 0;
   int n_txn = 0;
   logic [1:0] sel = 2'd0;
   logic [15:0] slv_word = 16'h0000;

   always #5 clk = ~clk;

   function automatic int div_of(input int g);
      return (g == 0) ? 2 : (g == 1) ? 1 : 255;
   endfunction

   function automatic int lat_of(input int g);
      return 2 * (CS_SETUP + 32 * div_of(g) + CS_HOLD) + CS_GAP + 1;
   endfunction

   adc_spi_reg_reader #(
      .CLK_DIV(2), .CS_SETUP(CS_SETUP),
      .CS_HOLD(CS_HOLD), .CS_GAP(CS_GAP)
   ) u0 (
      .FPGA_CLK1_32(clk), .reset_n(rst_n),
      .req_valid(req_valid[0]), .req_addr(req_addr[0]),
      .req_ready(req_ready[0]), .rsp_valid(rsp_valid[0]),
      .rsp_data(rsp_data[0]), .rsp_err(rsp_err[0]),
      .busy(busy[0]), .ss(ss[0]), .sck(sck[0]),
      .sdo(sdo[0]), .sdi(sdi)
   );

   adc_spi_reg_reader #(
      .CLK_DIV(1), .CS_SETUP(CS_SETUP),
      .CS_HOLD(CS_HOLD), .CS_GAP(CS_GAP)
   ) u1 (
      .FPGA_CLK1_32(clk), .reset_n(rst_n),
      .req_valid(req_valid[1]), .req_addr(req_addr[1]),
      .req_ready(req_ready[1]), .rsp_valid(rsp_valid[1]),
      .rsp_data(rsp_data[1]), .rsp_err(rsp_err[1]),
      .busy(busy[1]), .ss(ss[1]), .sck(sck[1]),
      .sdo(sdo[1]), .sdi(sdi)
   );

   adc_spi_reg_reader #(
      .CLK_DIV(255), .CS_SETUP(CS_SETUP),
      .CS_HOLD(CS_HOLD), .CS_GAP(CS_GAP)
   ) u2 (
      .FPGA_CLK1_32(clk), .reset_n(rst_n),
      .req_valid(req_valid[2]), .req_addr(req_addr[2]),
      .req_ready(req_ready[2]), .rsp_valid(rsp_valid[2]),
      .rsp_data(rsp_data[2]), .rsp_err(rsp_err[2]),
      .busy(busy[2]), .ss(ss[2]), .sck(sck[2]),
      .sdo(sdo[2]), .sdi(sdi)
   );

   wire m_ss   = ss[sel];
   wire m_sck  = sck[sel];
   wire m_sdo  = sdo[sel];
   wire m_busy = busy[sel];
   wire m_rv   = rsp_valid[sel];

   logic p_ss, p_sck, p_sdo, p_busy;
   int run, ss_hi, frise, trise, mbits;
   int tim_err, rsp_cnt;
   logic [15:0] s_sr, mosi;
   logic [15:0] mosi_q[$];

   wire sck_rise = m_sck & ~p_sck;
   wire sck_fall = ~m_sck & p_sck;
   wire ss_fall  = ~m_ss & p_ss;
   wire ss_rise  = m_ss & ~p_ss;

   // Slave model plus bus timing monitor on the selected instance
   always @(negedge clk) begin
      if (!rst_n) begin
         p_ss <= 1'b1; p_sck <= 1'b0;
         p_sdo <= 1'b0; p_busy <= 1'b0;
         run <= 0; ss_hi <= 0; frise <= 0;
         trise <= 0; mbits <= 0; sdi <= 1'b0;
      end else begin
         p_ss <= m_ss; p_sck <= m_sck;
         p_sdo <= m_sdo; p_busy <= m_busy;
         ss_hi <= m_ss ? ss_hi + 1 : 0;
         if (ss_fall) begin
            if (p_busy && ss_hi < CS_GAP) tim_err <= tim_err + 1;
            s_sr <= slv_word;
            frise <= 0; mbits <= 0; run <= 1;
         end else if (sck_rise) begin
            if (frise == 0 ? run != CS_SETUP : run != div_of(sel))
               tim_err <= tim_err + 1;
            frise <= frise + 1; trise <= trise + 1; run <= 1;
            sdi <= s_sr[15];
            s_sr <= {s_sr[14:0], 1'b0};
         end else if (sck_fall) begin
            if (run != div_of(sel)) tim_err <= tim_err + 1;
            run <= 1;
            mosi <= {mosi[14:0], m_sdo};
            mbits <= mbits + 1;
         end else begin
            run <= run + 1;
         end
         if (m_sdo != p_sdo && !sck_rise && !(frise == 16 && !m_sck))
            tim_err <= tim_err + 1;
         if (ss_rise && mbits == 16) mosi_q.push_back(mosi);
         if (m_rv) begin
            if (trise != 32) tim_err <= tim_err + 1;
            trise <= 0;
            rsp_cnt <= rsp_cnt + 1;
         end
      end
   end

   task automatic do_read(input int g, input logic [4:0] addr,
                          input logic [15:0] word, input string name);
      int q0, lat;
      logic exp_err;
      logic [15:0] cmd;
      cmd = {3'b001, addr, 8'h00};
      exp_err = word[15:8] != {3'b001, addr};
      sel = 2'(g);
      slv_word = word;
      q0 = mosi_q.size();
      @(negedge clk);
      lat = 0;
      while (req_ready[g] !== 1'b1 && lat < LIMIT) begin
         @(negedge clk); lat++;
      end
      req_addr[g] = addr;
      req_valid[g] = 1'b1;
      @(posedge clk); #1;
      req_valid[g] = 1'b0;
      req_addr[g] = 5'($urandom);
      n_cmp++;
      if (busy[g] !== 1'b1 || ss[g] !== 1'b0) begin
         n_bad++;
         $display("FAIL %s accept: busy=%b ss=%b want 1 0", name, busy[g], ss[g]);
      end
      lat = 1;
      while (rsp_valid[g] !== 1'b1 && lat < LIMIT) begin
         @(posedge clk); #1; lat++;
      end
      n_cmp++;
      if (lat != lat_of(g)) begin
         n_bad++;
         $display("FAIL %s latency: got %0d want %0d", name, lat, lat_of(g));
      end
      n_cmp++;
      if (rsp_data[g] !== word[7:0]) begin
         n_bad++;
         $display("FAIL %s data: got %h want %h", name, rsp_data[g], word[7:0]);
      end
      n_cmp++;
      if (rsp_err[g] !== exp_err) begin
         n_bad++;
         $display("FAIL %s err: got %b want %b", name, rsp_err[g], exp_err);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (rsp_valid[g] !== 1'b0 || req_ready[g] !== 1'b1 ||
          busy[g] !== 1'b0 || rsp_data[g] !== word[7:0]) begin
         n_bad++;
         $display("FAIL %s after: valid=%b ready=%b busy=%b data=%h want 0 1 0 %h",
                  name, rsp_valid[g], req_ready[g], busy[g], rsp_data[g], word[7:0]);
      end
      @(negedge clk);
      n_cmp++;
      if (mosi_q.size() != q0 + 2) begin
         n_bad++;
         $display("FAIL %s frames: got %0d want 2", name, mosi_q.size() - q0);
      end else if (mosi_q[q0] !== cmd || mosi_q[q0+1] !== 16'h0000) begin
         n_bad++;
         $display("FAIL %s mosi: got %h %h want %h 0000",
                  name, mosi_q[q0], mosi_q[q0+1], cmd);
      end
      n_txn++;
   endtask

   task automatic test_reset();
      #12;
      for (int g = 0; g < 3; g++) begin
         n_cmp++;
         if ({ss[g], sck[g], sdo[g], busy[g], rsp_valid[g], rsp_err[g]} !== 6'b100000 ||
             rsp_data[g] !== 8'h00) begin
            n_bad++;
            $display("FAIL reset%0d: ss/sck/sdo/busy/rv/err=%b%b%b%b%b%b data=%h want 100000 00",
                     g, ss[g], sck[g], sdo[g], busy[g], rsp_valid[g], rsp_err[g], rsp_data[g]);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (req_ready !== 3'b111) begin
         n_bad++;
         $display("FAIL reset ready: got %b want 111", req_ready);
      end
   endtask

   task automatic test_random();
      logic [4:0] a;
      logic [15:0] w;
      for (int i = 0; i < 4; i++) begin
         a = 5'($urandom);
         w[7:0] = 8'($urandom);
         w[15:8] = ($urandom_range(0, 1) == 1) ? {3'b001, a} : 8'($urandom);
         do_read(0, a, w, "random");
      end
   endtask

   task automatic test_back_to_back();
      int q0, lat;
      logic [15:0] w;
      logic exp2;
      w = {8'h21, 8'($urandom)};
      exp2 = w[15:8] != {3'b001, 5'h07};
      sel = 2'd0;
      slv_word = w;
      q0 = mosi_q.size();
      @(negedge clk);
      lat = 0;
      while (req_ready[0] !== 1'b1 && lat < LIMIT) begin
         @(negedge clk); lat++;
      end
      req_addr[0] = 5'h01;
      req_valid[0] = 1'b1;
      @(posedge clk); #1;
      req_addr[0] = 5'h07;
      lat = 1;
      while (rsp_valid[0] !== 1'b1 && lat < LIMIT) begin
         @(posedge clk); #1; lat++;
      end
      n_cmp++;
      if (lat != lat_of(0) || rsp_data[0] !== w[7:0] || rsp_err[0] !== 1'b0) begin
         n_bad++;
         $display("FAIL b2b first: lat=%0d data=%h err=%b want %0d %h 0",
                  lat, rsp_data[0], rsp_err[0], lat_of(0), w[7:0]);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (req_ready[0] !== 1'b1 || ss[0] !== 1'b1 || busy[0] !== 1'b0) begin
         n_bad++;
         $display("FAIL b2b idle: ready=%b ss=%b busy=%b want 1 1 0",
                  req_ready[0], ss[0], busy[0]);
      end
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      n_cmp++;
      if (busy[0] !== 1'b1 || ss[0] !== 1'b0) begin
         n_bad++;
         $display("FAIL b2b second accept: busy=%b ss=%b want 1 0", busy[0], ss[0]);
      end
      lat = 1;
      while (rsp_valid[0] !== 1'b1 && lat < LIMIT) begin
         @(posedge clk); #1; lat++;
      end
      n_cmp++;
      if (lat != lat_of(0) || rsp_data[0] !== w[7:0] || rsp_err[0] !== exp2) begin
         n_bad++;
         $display("FAIL b2b second: lat=%0d data=%h err=%b want %0d %h %b",
                  lat, rsp_data[0], rsp_err[0], lat_of(0), w[7:0], exp2);
      end
      @(posedge clk); #1;
      @(negedge clk);
      n_cmp++;
      if (mosi_q.size() != q0 + 4) begin
         n_bad++;
         $display("FAIL b2b frames: got %0d want 4", mosi_q.size() - q0);
      end else if (mosi_q[q0] !== {3'b001, 5'h01, 8'h00} || mosi_q[q0+1] !== 16'h0 ||
                   mosi_q[q0+2] !== {3'b001, 5'h07, 8'h00} || mosi_q[q0+3] !== 16'h0) begin
         n_bad++;
         $display("FAIL b2b mosi: got %h %h %h %h want 2100 0000 2700 0000",
                  mosi_q[q0], mosi_q[q0+1], mosi_q[q0+2], mosi_q[q0+3]);
      end
      n_txn += 2;
   endtask

   task automatic test_reset_mid();
      int q0, lat, r0;
      sel = 2'd0;
      slv_word = 16'($urandom);
      q0 = mosi_q.size();
      r0 = rsp_cnt;
      @(negedge clk);
      req_addr[0] = 5'($urandom);
      req_valid[0] = 1'b1;
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      lat = 0;
      while (!(mosi_q.size() == q0 + 1 && frise == 9) && lat < LIMIT) begin
         @(posedge clk); #1; lat++;
      end
      n_cmp++;
      if (lat >= LIMIT || ss[0] !== 1'b0) begin
         n_bad++;
         $display("FAIL midreset reach bit 9: waited=%0d ss=%b want <%0d 0", lat, ss[0], LIMIT);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({ss[0], sck[0], sdo[0], busy[0], rsp_valid[0], rsp_err[0]} !== 6'b100000 ||
          rsp_data[0] !== 8'h00) begin
         n_bad++;
         $display("FAIL midreset async: ss/sck/sdo/busy/rv/err=%b%b%b%b%b%b data=%h want 100000 00",
                  ss[0], sck[0], sdo[0], busy[0], rsp_valid[0], rsp_err[0], rsp_data[0]);
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (req_ready[0] !== 1'b1) begin
         n_bad++;
         $display("FAIL midreset ready: got %b want 1", req_ready[0]);
      end
      repeat (300) @(posedge clk);
      #1;
      n_cmp++;
      if (rsp_cnt != r0 || busy[0] !== 1'b0) begin
         n_bad++;
         $display("FAIL midreset no response: pulses=%0d busy=%b want 0 0", rsp_cnt - r0, busy[0]);
      end
      do_read(0, 5'h02, {8'h22, 8'($urandom)}, "after reset");
   endtask

   task automatic test_divider();
      do_read(1, 5'h03, 16'h2355, "div1");
      do_read(2, 5'h03, 16'h2355, "div255");
   endtask

   task automatic test_spi_timing();
      @(negedge clk);
      n_cmp++;
      if (tim_err != 0) begin
         n_bad++;
         $display("FAIL spi timing: violations=%0d want 0", tim_err);
      end
      n_cmp++;
      if (rsp_cnt != n_txn) begin
         n_bad++;
         $display("FAIL rsp pulses: got %0d want %0d", rsp_cnt, n_txn);
      end
   endtask

   initial begin
      test_reset();
      do_read(0, 5'h03, 16'h2355, "basic");
      do_read(0, 5'h1F, 16'h1EA5, "echo");
      test_random();
      test_back_to_back();
      test_reset_mid();
      test_divider();
      test_spi_timing();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
